// File: rtl/param_lfsr.sv
// Fibonacci-style LFSR with seed loading, zero-seed protection and period measurement.
// The period is the number of steps needed to return to the last loaded (reference) value.
module param_lfsr #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(6'b110000),
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             seed_err,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_vld
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             wrap_q, wrap_d;
  logic             seed_err_q, seed_err_d;

  logic             fb;
  logic [WIDTH-1:0] step;

  assign fb = ^(q_q & TAPS);

  // A legal TAPS (MSB set) can never step a non-zero state to zero; the
  // substitution only guards against a misconfigured mask.
  always_comb begin
    step = {q_q[WIDTH-2:0], fb};
    if (step == '0) begin
      step = INIT;
    end
  end

  always_comb begin
    q_d          = q_q;
    ref_d        = ref_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    wrap_d       = 1'b0;
    seed_err_d   = 1'b0;
    if (load) begin
      if (seed != '0) begin
        q_d   = seed;
        ref_d = seed;
      end else begin
        q_d        = INIT;
        ref_d      = INIT;
        seed_err_d = 1'b1;
      end
      cnt_d = '0;
    end else if (enable) begin
      q_d = step;
      if (step == ref_q) begin
        wrap_d       = 1'b1;
        period_d     = cnt_q + ONE;
        period_vld_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= INIT;
      ref_q        <= INIT;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      wrap_q       <= 1'b0;
      seed_err_q   <= 1'b0;
    end else begin
      q_q          <= q_d;
      ref_q        <= ref_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      wrap_q       <= wrap_d;
      seed_err_q   <= seed_err_d;
    end
  end

  assign q          = q_q;
  assign bit_out    = q_q[WIDTH-1];
  assign seed_err   = seed_err_q;
  assign wrap       = wrap_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;

endmodule

// File: tb/tb_param_lfsr.sv
// Directed bench for param_lfsr (WIDTH=6, TAPS=110000, INIT=1) with a queued scoreboard.
// Driver pushes the expected post-edge outputs; the monitor pops and compares after each edge.
module tb_param_lfsr;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] seed;
  logic         enable;
  logic [W-1:0] q;
  logic         bit_out;
  logic         seed_err;
  logic         wrap;
  logic [W-1:0] period;
  logic         period_vld;

  param_lfsr #(.WIDTH(6), .TAPS(6'b110000), .INIT(6'd1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .seed       (seed),
    .enable     (enable),
    .q          (q),
    .bit_out    (bit_out),
    .seed_err   (seed_err),
    .wrap       (wrap),
    .period     (period),
    .period_vld (period_vld)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string        name;
    logic         chk_q;
    logic [W-1:0] q;
    logic         wrap;
    logic         seed_err;
    logic [W-1:0] period;
    logic         period_vld;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk_q) begin
        check($sformatf("%s.q", mon_e.name), 32'(q), 32'(mon_e.q));
        check($sformatf("%s.bit_out", mon_e.name), 32'(bit_out), 32'(mon_e.q[W-1]));
      end
      check($sformatf("%s.wrap", mon_e.name), 32'(wrap), 32'(mon_e.wrap));
      check($sformatf("%s.seed_err", mon_e.name), 32'(seed_err), 32'(mon_e.seed_err));
      check($sformatf("%s.period", mon_e.name), 32'(period), 32'(mon_e.period));
      check($sformatf("%s.period_vld", mon_e.name), 32'(period_vld), 32'(mon_e.period_vld));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input string name, input logic ld, input logic [W-1:0] sd, input logic en,
                       input logic chk_q, input logic [W-1:0] eq, input logic ew, input logic ese,
                       input logic [W-1:0] ep, input logic ev);
    exp_t e;
    @(negedge clk);
    load   = ld;
    seed   = sd;
    enable = en;
    e.name       = name;
    e.chk_q      = chk_q;
    e.q          = eq;
    e.wrap       = ew;
    e.seed_err   = ese;
    e.period     = ep;
    e.period_vld = ev;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b0;
    seed   = '0;
    while (exp_q.size() > 0 && budget < 8) begin
      @(negedge clk);
      budget++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s.q", tag), 32'(q), 32'd1);
    check($sformatf("%s.bit_out", tag), 32'(bit_out), 32'd0);
    check($sformatf("%s.wrap", tag), 32'(wrap), 32'd0);
    check($sformatf("%s.seed_err", tag), 32'(seed_err), 32'd0);
    check($sformatf("%s.period", tag), 32'(period), 32'd0);
    check($sformatf("%s.period_vld", tag), 32'(period_vld), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] walk [6];
  logic         en_t;
  int           k;

  initial begin
    walk[0] = 6'b000010; walk[1] = 6'b000100; walk[2] = 6'b001000;
    walk[3] = 6'b010000; walk[4] = 6'b100001; walk[5] = 6'b000011;

    rst_n = 1'b0; load = 1'b0; enable = 1'b0; seed = '0;
    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Six steps from INIT
    for (int i = 0; i < 6; i++) begin
      drive($sformatf("walk%0d", i), 1'b0, '0, 1'b1, 1'b1, walk[i], 1'b0, 1'b0, '0, 1'b0);
    end
    // Zero seed replaced by INIT, pulse lasts one cycle
    drive("zero_seed", 1'b1, 6'h00, 1'b0, 1'b1, 6'h01, 1'b0, 1'b1, '0, 1'b0);
    drive("after_zero", 1'b0, '0, 1'b1, 1'b1, 6'h02, 1'b0, 1'b0, '0, 1'b0);
    drive("hold", 1'b0, '0, 1'b0, 1'b1, 6'h02, 1'b0, 1'b0, '0, 1'b0);
    drain();

    // Full period from 0x2A
    drive("load_2a", 1'b1, 6'h2A, 1'b0, 1'b1, 6'h2A, 1'b0, 1'b0, '0, 1'b0);
    for (int s = 1; s <= 63; s++) begin
      drive($sformatf("run2a_%0d", s), 1'b0, '0, 1'b1, (s == 1 || s == 63),
            (s == 1) ? 6'h15 : 6'h2A, (s == 63), 1'b0,
            (s == 63) ? 6'd63 : 6'd0, (s == 63));
    end
    drive("hold_2a", 1'b0, '0, 1'b0, 1'b1, 6'h2A, 1'b0, 1'b0, 6'd63, 1'b1);
    drain();

    // Load wins over enable and restarts the counter
    for (int s = 1; s <= 10; s++) begin
      drive($sformatf("pre15_%0d", s), 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 6'd63, 1'b1);
    end
    drive("load_en_15", 1'b1, 6'h15, 1'b1, 1'b1, 6'h15, 1'b0, 1'b0, 6'd63, 1'b1);
    for (int s = 1; s <= 63; s++) begin
      drive($sformatf("run15_%0d", s), 1'b0, '0, 1'b1, (s == 1 || s == 63),
            (s == 1) ? 6'h2B : 6'h15, (s == 63), 1'b0, 6'd63, 1'b1);
    end
    drive("hold_15", 1'b0, '0, 1'b0, 1'b1, 6'h15, 1'b0, 1'b0, 6'd63, 1'b1);
    drain();

    // Enable toggling every cycle from reset: wrap after 63 enabled edges
    async_reset("rst_toggle");
    for (int i = 0; i < 126; i++) begin
      en_t = i[0];
      k    = (i + 1) / 2;
      drive($sformatf("toggle_%0d", i), 1'b0, '0, en_t, (i < 2 || i == 125),
            (i == 1) ? 6'h02 : 6'h01, (i == 125), 1'b0,
            (i == 125) ? 6'd63 : 6'd0, (i == 125));
    end
    drive("hold_toggle", 1'b0, '0, 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, 6'd63, 1'b1);
    drain();
    check("toggle_enabled_edges", 32'(k), 32'd63);

    // Reset mid-cycle while a pulse is high; load/enable on the reset edge are discarded
    drive("zero_seed2", 1'b1, 6'h00, 1'b0, 1'b1, 6'h01, 1'b0, 1'b1, 6'd63, 1'b1);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    load   = 1'b1;
    seed   = 6'h2A;
    enable = 1'b1;
    #1;
    check_reset("mid_rst");
    @(posedge clk);
    #1;
    check_reset("rst_edge");
    @(negedge clk);
    rst_n  = 1'b1;
    load   = 1'b0;
    seed   = '0;
    enable = 1'b0;
    drive("post_rst_hold", 1'b0, '0, 1'b0, 1'b1, 6'h01, 1'b0, 1'b0, '0, 1'b0);
    drive("post_rst_step", 1'b0, '0, 1'b1, 1'b1, 6'h02, 1'b0, 1'b0, '0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
